// File: rtl/trace_player_if.sv
`default_nettype none
// ============================================================================
// Module   : trace_player_if
// Purpose  : Host load strobes, playback control and replayed-sample outputs
// Revision : 1.0 - initial release
// ============================================================================
interface trace_player_if #(
    parameter int AW = 10,
    parameter int DW = 4
) ();
    logic          ld_reset;
    logic          ld_wr;
    logic          ld_sel;
    logic [7:0]    ld_data;
    logic [7:0]    play_ctl;
    logic [DW-1:0] ch0;
    logic [DW-1:0] ch1;
    logic [DW-1:0] ch2;
    logic [DW-1:0] ch3;
    logic          play_valid;
    logic          busy;
    logic          done;
    logic [AW:0]   ld_count;
    logic          full;

    modport master (
        output ld_reset, ld_wr, ld_sel, ld_data, play_ctl,
        input  ch0, ch1, ch2, ch3, play_valid, busy, done, ld_count, full
    );

    modport slave (
        input  ld_reset, ld_wr, ld_sel, ld_data, play_ctl,
        output ch0, ch1, ch2, ch3, play_valid, busy, done, ld_count, full
    );
endinterface
`default_nettype wire

// File: rtl/trace_player.sv
`default_nettype none
// ============================================================================
// Module   : trace_player
// Purpose  : Replays a host-loaded 4-channel sample buffer as converter codes
// Revision : 1.0 - initial release
// ============================================================================
module trace_player #(
    parameter int AW = 10,
    parameter int DW = 4
) (
    input  logic          clk8M,
    input  logic          reset_n,
    trace_player_if.slave bus
);
    localparam int          c_DEPTH = 2**AW;
    localparam int          c_EW    = 4*DW;
    localparam logic [AW:0] c_FULL  = (AW+1)'(c_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRIME = 2'd1,
        S_PLAY  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW:0]     r_ld_count;
    logic [7:0]      r_stage;
    logic [AW-1:0]   r_ptr;
    logic [AW-1:0]   w_ptr_nxt;
    logic [5:0]      r_div;
    logic [5:0]      w_div_nxt;
    logic            r_valid;
    logic            w_valid_nxt;
    logic [c_EW-1:0] r_ch;
    logic [c_EW-1:0] r_mem [c_DEPTH];

    logic            w_rd_en;
    logic            w_clr;
    logic [AW-1:0]   w_rd_addr;
    logic            w_en;
    logic            w_loop;
    logic [5:0]      w_rate;
    logic            w_load_ok;
    logic            w_full;
    logic            w_commit;
    logic [AW-1:0]   w_ptr_inc;
    logic [AW-1:0]   w_ptr_first;

    assign w_en   = bus.play_ctl[7];
    assign w_loop = bus.play_ctl[6];
    assign w_rate = bus.play_ctl[5:0];

    // ------------------------------------------------------------------
    // Host load path
    // ------------------------------------------------------------------
    assign w_load_ok = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_full    = (r_ld_count == c_FULL);
    assign w_commit  = w_load_ok && !bus.ld_reset && bus.ld_wr && bus.ld_sel && !w_full;

    always_ff @(posedge clk8M or negedge reset_n) begin
        if (!reset_n) begin
            r_ld_count <= '0;
            r_stage    <= '0;
        end else if (w_load_ok) begin
            if (bus.ld_reset) begin
                r_ld_count <= '0;
            end else if (bus.ld_wr) begin
                if (!bus.ld_sel) begin
                    r_stage <= bus.ld_data;
                end else if (!w_full) begin
                    r_ld_count <= r_ld_count + (AW+1)'(1);
                end
            end
        end
    end

    always_ff @(posedge clk8M) begin
        if (w_commit) begin
            r_mem[r_ld_count[AW-1:0]] <= {bus.ld_data, r_stage};
        end
    end

    // The buffer read register doubles as the sample output register, so a
    // sample addressed during a cycle appears on ch* right after that edge.
    always_ff @(posedge clk8M or negedge reset_n) begin
        if (!reset_n) begin
            r_ch <= '0;
        end else if (w_clr) begin
            r_ch <= '0;
        end else if (w_rd_en) begin
            r_ch <= r_mem[w_rd_addr];
        end
    end

    // ------------------------------------------------------------------
    // Playback sequencing
    // ------------------------------------------------------------------
    assign w_ptr_inc   = (({1'b0, r_ptr} + (AW+1)'(1)) == r_ld_count) ? '0 : r_ptr + AW'(1);
    assign w_ptr_first = (r_ld_count == (AW+1)'(1)) ? '0 : AW'(1);

    always_ff @(posedge clk8M or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_div   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_div   <= w_div_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_div_nxt   = r_div;
        w_valid_nxt = 1'b0;
        w_rd_en     = 1'b0;
        w_clr       = 1'b0;
        w_rd_addr   = r_ptr;

        unique case (r_state)
            S_IDLE: begin
                w_ptr_nxt = '0;
                w_div_nxt = '0;
                if (w_en) begin
                    w_state_nxt = (r_ld_count != '0) ? S_PRIME : S_DONE;
                end
            end
            S_PRIME: begin
                if (!w_en) begin
                    w_state_nxt = S_IDLE;
                    w_clr       = 1'b1;
                end else begin
                    w_rd_addr   = '0;
                    w_rd_en     = 1'b1;
                    w_valid_nxt = 1'b1;
                    w_ptr_nxt   = w_ptr_first;
                    w_div_nxt   = '0;
                    w_state_nxt = S_PLAY;
                end
            end
            S_PLAY: begin
                if (!w_en) begin
                    w_state_nxt = S_IDLE;
                    w_clr       = 1'b1;
                end else if (r_div >= w_rate) begin
                    // A pointer back at 0 means the sample just held was the last one
                    w_div_nxt = '0;
                    if ((r_ptr == '0) && !w_loop) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_rd_en     = 1'b1;
                        w_valid_nxt = 1'b1;
                        w_ptr_nxt   = w_ptr_inc;
                    end
                end else begin
                    w_div_nxt = r_div + 6'd1;
                end
            end
            S_DONE: begin
                if (!w_en) begin
                    w_state_nxt = S_IDLE;
                    w_clr       = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_clr       = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.ch0        = r_ch[DW-1:0];
    assign bus.ch1        = r_ch[2*DW-1:DW];
    assign bus.ch2        = r_ch[3*DW-1:2*DW];
    assign bus.ch3        = r_ch[4*DW-1:3*DW];
    assign bus.play_valid = r_valid;
    assign bus.busy       = (r_state == S_PRIME) || (r_state == S_PLAY);
    assign bus.done       = (r_state == S_DONE);
    assign bus.ld_count   = r_ld_count;
    assign bus.full       = w_full;
endmodule
`default_nettype wire

// File: tb/tb_trace_player.sv
`default_nettype none
// ============================================================================
// Module   : tb_trace_player
// Purpose  : Randomized self-checking bench for trace_player against a timing model
// Revision : 1.0 - initial release
// ============================================================================
module tb_trace_player;
    localparam int AW    = 10;
    localparam int DW    = 4;
    localparam int DEPTH = 1 << AW;

    logic clk8M = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_errors = 0;

    trace_player_if #(.AW(AW), .DW(DW)) bus ();

    trace_player #(.AW(AW), .DW(DW)) dut (
        .clk8M   (clk8M),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk8M = ~clk8M;

    logic [15:0] ch_all;
    assign ch_all = {bus.ch3, bus.ch2, bus.ch1, bus.ch0};

    // Reference: list of committed entries plus the last low byte written
    logic [15:0] model_buf[$];
    logic [7:0]  model_stage = 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " ch"},    32'(ch_all),         32'h0);
        check({tag, " valid"}, 32'(bus.play_valid), 32'h0);
        check({tag, " busy"},  32'(bus.busy),       32'h0);
        check({tag, " done"},  32'(bus.done),       32'h0);
    endtask

    task automatic write_byte(input logic sel, input logic [7:0] data);
        bus.ld_wr   = 1'b1;
        bus.ld_sel  = sel;
        bus.ld_data = data;
        @(negedge clk8M);
        bus.ld_wr   = 1'b0;
    endtask

    task automatic load_entry(input logic [7:0] lo, input logic [7:0] hi, input bit skip_lo);
        if (!skip_lo) begin
            write_byte(1'b0, lo);
            model_stage = lo;
        end
        write_byte(1'b1, hi);
        if (model_buf.size() < DEPTH) model_buf.push_back({hi, model_stage});
    endtask

    task automatic clear_load();
        bus.ld_reset = 1'b1;
        @(negedge clk8M);
        bus.ld_reset = 1'b0;
        model_buf.delete();
    endtask

    // Expected behaviour after the j-th edge following the edge that sees enable
    task automatic play_run(input logic [5:0] rate, input logic loop, input int ncyc, input bit noise);
        int          n;
        int          p;
        int          m;
        int          q;
        logic [15:0] e_ch;
        logic        e_valid;
        logic        e_busy;
        logic        e_done;
        n = model_buf.size();
        p = int'(rate) + 1;
        bus.play_ctl = {1'b1, loop, rate};
        for (int j = 0; j < ncyc; j++) begin
            if (noise && j > 0 && $urandom_range(0, 2) == 0) begin
                bus.ld_wr    = 1'b1;
                bus.ld_sel   = 1'($urandom_range(0, 1));
                bus.ld_data  = 8'($urandom);
                bus.ld_reset = 1'($urandom_range(0, 1));
            end
            @(negedge clk8M);
            bus.ld_wr    = 1'b0;
            bus.ld_reset = 1'b0;
            if (j == 0) begin
                e_busy = 1'b1; e_done = 1'b0; e_valid = 1'b0; e_ch = 16'h0;
            end else begin
                m = j - 1;
                q = m / p;
                if (!loop && q >= n) begin
                    e_busy = 1'b0; e_done = 1'b1; e_valid = 1'b0; e_ch = model_buf[n-1];
                end else begin
                    e_busy = 1'b1; e_done = 1'b0; e_valid = (m % p == 0); e_ch = model_buf[q % n];
                end
            end
            check("play ch",    32'(ch_all),         32'(e_ch));
            check("play valid", 32'(bus.play_valid), 32'(e_valid));
            check("play busy",  32'(bus.busy),       32'(e_busy));
            check("play done",  32'(bus.done),       32'(e_done));
        end
        check("run ld_count", 32'(bus.ld_count), 32'(n));
        bus.play_ctl[7] = 1'b0;
        @(negedge clk8M);
        check_idle("stop");
    endtask

    initial begin
        int          n;
        logic [5:0]  rate;
        logic        loop;
        reset_n      = 1'b0;
        bus.ld_reset = 1'b0;
        bus.ld_wr    = 1'b0;
        bus.ld_sel   = 1'b0;
        bus.ld_data  = 8'h00;
        bus.play_ctl = 8'h00;
        repeat (3) @(negedge clk8M);
        check_idle("reset");
        check("reset ld_count", 32'(bus.ld_count), 32'h0);
        check("reset full",     32'(bus.full),     32'h0);
        reset_n = 1'b1;
        @(negedge clk8M);

        // Three entries, one-shot then looped
        load_entry(8'h21, 8'h43, 1'b0);
        load_entry(8'h65, 8'h87, 1'b0);
        load_entry(8'hA9, 8'hCB, 1'b0);
        check("load3 ld_count", 32'(bus.ld_count), 32'd3);
        play_run(6'd0, 1'b0, 8, 1'b0);
        play_run(6'd3, 1'b1, 40, 1'b1);

        // Random sequences, rates and loop modes; loads are poked during looped runs
        repeat (12) begin
            clear_load();
            n = $urandom_range(1, 24);
            for (int i = 0; i < n; i++) begin
                load_entry(8'($urandom), 8'($urandom), (i > 0) && ($urandom_range(0, 3) == 0));
            end
            rate = 6'($urandom_range(0, 6));
            loop = 1'($urandom_range(0, 1));
            play_run(rate, loop, n * (int'(rate) + 1) + $urandom_range(2, 10), loop);
        end

        // Empty buffer goes straight to DONE without any valid
        clear_load();
        bus.play_ctl = 8'h80;
        @(negedge clk8M);
        check("empty done", 32'(bus.done), 32'h1);
        check("empty busy", 32'(bus.busy), 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk8M);
            check("empty valid", 32'(bus.play_valid), 32'h0);
        end
        bus.play_ctl = 8'h00;
        @(negedge clk8M);
        check_idle("empty stop");

        // ld_reset wins over a simultaneous commit
        load_entry(8'h11, 8'h22, 1'b0);
        check("pre-prio ld_count", 32'(bus.ld_count), 32'd1);
        bus.ld_reset = 1'b1;
        bus.ld_wr    = 1'b1;
        bus.ld_sel   = 1'b1;
        @(negedge clk8M);
        bus.ld_reset = 1'b0;
        bus.ld_wr    = 1'b0;
        model_buf.delete();
        check("prio ld_count", 32'(bus.ld_count), 32'd0);

        // Fill to capacity, one extra commit, full-length playback
        for (int i = 0; i < DEPTH; i++) begin
            load_entry(8'($urandom), 8'($urandom), 1'b0);
            if (i == DEPTH - 2) check("almost full", 32'(bus.full), 32'h0);
        end
        check("full flag",     32'(bus.full),     32'h1);
        check("full ld_count", 32'(bus.ld_count), 32'(DEPTH));
        load_entry(8'h5A, 8'hA5, 1'b0);
        check("overflow ld_count", 32'(bus.ld_count), 32'(DEPTH));
        check("overflow full",     32'(bus.full),     32'h1);
        play_run(6'd0, 1'b0, DEPTH + 4, 1'b0);

        // Asynchronous reset in the middle of a looped playback
        bus.play_ctl = {1'b1, 1'b1, 6'd2};
        repeat (7) @(negedge clk8M);
        check("pre-reset busy", 32'(bus.busy), 32'h1);
        #2 reset_n = 1'b0;
        #1;
        check_idle("async reset");
        check("async reset ld_count", 32'(bus.ld_count), 32'h0);
        check("async reset full",     32'(bus.full),     32'h0);
        bus.play_ctl = 8'h00;
        @(negedge clk8M);
        reset_n = 1'b1;
        repeat (2) @(negedge clk8M);
        check_idle("post reset");
        check("post reset ld_count", 32'(bus.ld_count), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/trace_player.md
Name: trace_player

Overview:
- Playback counterpart of the trace recorder: the host loads a 4-channel x 4-bit sample sequence into a buffer, then the block replays it on clk8M as synthetic converter codes for self-test of the filter/detector chain.
- Sits between the register block (host load strobes, already synchronised into clk8M) and the conv input muxes of the detector pipeline.
- Supports one-shot or looped playback at a programmable sample rate.

Parameters:
AW, 10, buffer address width; depth = 2**AW entries of 16 bits (4 channels x 4 bits)
DW, 4, bits per channel sample

Ports:
clk8M  in  1  pipeline clock
reset_n  in  1  asynchronous active-low reset
ld_reset  in  1  single-cycle pulse; clears load pointer/count
ld_wr  in  1  single-cycle pulse; host byte write
ld_sel  in  1  0 = byte {ch1,ch0}, 1 = byte {ch3,ch2} and commit entry
ld_data  in  8  host byte; [3:0] = lower channel, [7:4] = upper channel
play_ctl  in  8  [7] enable, [6] loop, [5:0] rate (sample period = rate+1 clocks)
ch0, ch1, ch2, ch3  out  DW each  replayed samples (registered)
play_valid  out  1  one-cycle pulse when ch0..ch3 take a new sample
busy  out  1  high in PRIME/PLAY
done  out  1  high in DONE
ld_count  out  AW+1  entries committed (0..2**AW)
full  out  1  ld_count == 2**AW

Behaviour:
- Reset: state IDLE; ch0..ch3 = 0, play_valid = 0, busy = 0, done = 0, ld_count = 0, full = 0, staging register = 0, read pointer = 0, divider = 0.
- Interface: reset_n is asynchronous, active-low; clock is clk8M.
- Load (accepted only in IDLE or DONE; ignored while busy):
  - ld_reset sets ld_count = 0. ld_reset takes priority over a simultaneous ld_wr.
  - ld_wr with ld_sel = 0 stores ld_data into the 8-bit staging register.
  - ld_wr with ld_sel = 1 writes {ld_data, staging} to buffer[ld_count] and increments ld_count.
  - When full, commits are ignored and ld_count saturates at 2**AW.
  - The staging register holds its value after a commit, so consecutive ld_sel = 1 writes reuse the last {ch1,ch0} byte.
- Buffer: synchronous read with one-cycle latency. Implementation is inferred RAM.
- State machine (states IDLE, PRIME, PLAY, DONE):
  - IDLE -> PRIME when enable = 1 and ld_count != 0. IDLE -> DONE when enable = 1 and ld_count == 0; no valid is emitted in that case.
  - PRIME: read pointer = 0, address 0 issued, divider cleared. Lasts exactly 1 cycle, then -> PLAY.
  - PLAY, first cycle: ch* = buffer[0], play_valid = 1. If enable rises in IDLE at cycle T, the first valid is at T+2.
  - PLAY, subsequent samples: each new sample is presented every rate+1 cycles, with a play_valid pulse. The next address is prefetched during the hold period, so there is no extra gap; at rate = 0, valid is high every cycle.
  - End of sequence: sample ld_count-1 is held for its full rate+1 cycles.
    - loop = 0: -> DONE; ch* hold the last sample.
    - loop = 1: sample 0 follows with the same spacing; the pointer wraps to 0, and also wraps at 2**AW-1 when full.
  - play_ctl[6:0] is sampled live; a change takes effect at the next sample boundary.
  - DONE -> IDLE when enable = 0.
  - Enable deasserted in PRIME/PLAY -> IDLE on the next edge.
  - Entering IDLE clears ch0..ch3 to 0 and play_valid to 0.
- Reset mid-operation: asynchronous return to the reset values. Buffer contents need not be preserved.
- Width rules: ld_count is AW+1 bits; the read pointer is AW bits and wraps modulo ld_count.

Test Plan:
1. Load 3 entries ({0x21,0x43}, {0x65,0x87}, {0xA9,0xCB}); rate = 0, loop = 0; enable at cycle T -> ld_count = 3; valid at T+2, T+3, T+4; ch0..ch3 = 1,2,3,4 / 5,6,7,8 / 9,A,B,C; done at T+5; outputs hold 9,A,B,C until enable = 0, then all 0.
2. Same load, rate = 3, loop = 1, run 40 cycles -> valid every 4 cycles; sample order 0,1,2,0,1,2,...; busy stays high; enable = 0 -> IDLE next cycle, ch* = 0.
3. Commit 1025 entries -> full = 1 and ld_count = 1024 after the 1024th commit; the 1025th is ignored; playback rate = 0 yields 1024 distinct samples, then done.
4. ld_count = 0, enable = 1 -> DONE on the next cycle; no play_valid; done = 1.
5. ld_wr and ld_reset during PLAY -> ignored; ld_count is unchanged. ld_reset together with ld_wr in IDLE -> ld_count = 0.
6. Assert reset_n low mid-PLAY -> all outputs 0 immediately (asynchronous); after release, state is IDLE and ld_count = 0.
